// File: rtl/pci_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// pci_bus_arbiter_if
//
// Purpose: bundles the request/grant and bus-monitor signals that connect
// the PCI central arbiter to the bus masters and the shared bus.
//
// Signals (active-low names end in _n; framein and irdy are active low too):
//   req_n        REQ# per master
//   framein      bus FRAME#
//   irdy         bus IRDY#
//   gnt_n        GNT# per master (registered in the arbiter)
//   owner        index of the current grantee / bus owner
//   owner_valid  owner is meaningful (PARK, GRANT, BUSY)
//   bus_busy     arbiter is in BUSY
//   timeout      one-cycle pulse when a grant is revoked by the idle timer
//
// Modports:
//   master  arbiter view: samples requests and bus state, drives grants
//   slave   bus/master view: drives requests and bus state, sees grants
// ---------------------------------------------------------------------------
interface pci_bus_arbiter_if #(
  parameter int N_MASTERS = 4
) ();

  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0] req_n;
  logic                 framein;
  logic                 irdy;
  logic [N_MASTERS-1:0] gnt_n;
  logic [OW-1:0]        owner;
  logic                 owner_valid;
  logic                 bus_busy;
  logic                 timeout;

  modport master (
    input  req_n,
    input  framein,
    input  irdy,
    output gnt_n,
    output owner,
    output owner_valid,
    output bus_busy,
    output timeout
  );

  modport slave (
    output req_n,
    output framein,
    output irdy,
    input  gnt_n,
    input  owner,
    input  owner_valid,
    input  bus_busy,
    input  timeout
  );

endinterface

// File: rtl/pci_bus_arbiter.sv
// ---------------------------------------------------------------------------
// pci_bus_arbiter
//
// Purpose: central round-robin arbiter for a shared PCI bus. Grants one
// initiator at a time through active-low GNT#, tracks bus ownership from
// FRAME#/IRDY#, parks the bus on a default master when nobody requests and
// revokes grants that leave the bus idle for too long.
//
// Ports:
//   clock   in   bus clock, all logic on the rising edge
//   reset   in   synchronous, active-high
//   bus     arbiter side (master modport) of pci_bus_arbiter_if:
//           req_n/framein/irdy in, gnt_n/owner/owner_valid/bus_busy/timeout out
//
// Parameters:
//   N_MASTERS     number of requesting masters (2..8)
//   PARK_EN       1: park the bus on PARK_MASTER when no one requests
//   PARK_MASTER   index of the park master
//   IDLE_TIMEOUT  GRANT cycles without FRAME# before the grant is revoked (>=2)
// ---------------------------------------------------------------------------
module pci_bus_arbiter #(
  parameter int N_MASTERS    = 4,
  parameter bit PARK_EN      = 1'b1,
  parameter int PARK_MASTER  = 0,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  pci_bus_arbiter_if.master  bus
);

  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  localparam logic [OW-1:0]        PARK_IDX = OW'(PARK_MASTER);
  localparam logic [N_MASTERS-1:0] PARK_OH  = N_MASTERS'(1) << PARK_MASTER;
  // Timer value seen during the last permitted idle GRANT cycle.
  localparam logic [TW-1:0]        TIMER_LAST = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PARK  = 2'd1,
    GRANT = 2'd2,
    BUSY  = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [OW-1:0]        owner_reg, owner_next;
  logic [OW-1:0]        ptr_reg, ptr_next;
  logic [TW-1:0]        timer_reg, timer_next;
  logic [N_MASTERS-1:0] gnt_n_reg, gnt_n_next;
  logic                 timeout_reg, timeout_next;

  // Active-high view of the requests.
  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] owner_oh;
  logic [N_MASTERS-1:0] sel_oh;
  logic [OW-1:0]        sel;
  logic                 any_req;
  logic                 others_req;
  logic                 owner_req;
  logic                 bus_idle;
  logic                 busy_keep;

  assign req = ~bus.req_n;

  // One-hot decodes of the current owner and the round-robin winner.
  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_onehot
      assign owner_oh[gi] = (owner_reg == OW'(gi));
      assign sel_oh[gi]   = (sel == OW'(gi));
    end
  endgenerate

  assign any_req    = |req;
  assign owner_req  = |(req & owner_oh);
  assign others_req = |(req & ~owner_oh);
  assign bus_idle   = bus.framein & bus.irdy;

  // In BUSY the owner keeps GNT# only while it is the sole requester;
  // anyone else asking pulls GNT# so the owner ends after its current
  // transaction (the PCI latency-timer mechanism does the rest).
  assign busy_keep  = owner_req & ~others_req;

  // Round-robin selection: first requester scanning from ptr+1 upward with
  // wrap. ptr holds the last master that won the bus, so it becomes lowest
  // priority for the next arbitration.
  always_comb begin
    logic found;
    int   idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= N_MASTERS) begin
        idx = idx - N_MASTERS;
      end
      if (!found && req[idx[OW-1:0]]) begin
        sel   = idx[OW-1:0];
        found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic. GNT# is computed for the state being
  // entered and registered, so the grant lines never glitch.
  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    ptr_next     = ptr_reg;
    timer_next   = timer_reg;
    gnt_n_next   = '1;
    timeout_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = GRANT;
          owner_next = sel;
          timer_next = '0;
          gnt_n_next = ~sel_oh;
        end else if (PARK_EN) begin
          state_next = PARK;
          owner_next = PARK_IDX;
          gnt_n_next = ~PARK_OH;
        end
      end

      PARK: begin
        if (!bus.framein) begin
          // Park master started a transaction without requesting.
          state_next = BUSY;
          gnt_n_next = busy_keep ? ~owner_oh : '1;
        end else if (others_req) begin
          // Release the park grant first so handoff always has a gap.
          state_next = IDLE;
        end else if (owner_req) begin
          // Same master: GNT# stays low across the transition.
          state_next = GRANT;
          timer_next = '0;
          gnt_n_next = ~owner_oh;
        end else begin
          gnt_n_next = ~owner_oh;
        end
      end

      GRANT: begin
        if (!bus.framein) begin
          // FRAME# has priority over both withdrawal and timer expiry.
          state_next = BUSY;
          ptr_next   = owner_reg;
          gnt_n_next = busy_keep ? ~owner_oh : '1;
        end else if (!owner_req) begin
          state_next = IDLE;
        end else if (timer_reg == TIMER_LAST) begin
          // Stalled master: revoke and demote it to lowest priority.
          state_next   = IDLE;
          timeout_next = 1'b1;
          ptr_next     = owner_reg;
        end else begin
          timer_next = timer_reg + 1'b1;
          gnt_n_next = ~owner_oh;
        end
      end

      BUSY: begin
        if (bus_idle) begin
          state_next = IDLE;
        end else begin
          gnt_n_next = busy_keep ? ~owner_oh : '1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      owner_reg   <= '0;
      ptr_reg     <= OW'(N_MASTERS - 1);
      timer_reg   <= '0;
      gnt_n_reg   <= '1;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      ptr_reg     <= ptr_next;
      timer_reg   <= timer_next;
      gnt_n_reg   <= gnt_n_next;
      timeout_reg <= timeout_next;
    end
  end

  assign bus.gnt_n       = gnt_n_reg;
  assign bus.owner       = owner_reg;
  assign bus.owner_valid = (state_reg != IDLE);
  assign bus.bus_busy    = (state_reg == BUSY);
  assign bus.timeout     = timeout_reg;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pci_bus_arbiter
//
// Directed bench for pci_bus_arbiter (N_MASTERS=4, PARK_EN=1, PARK_MASTER=0,
// IDLE_TIMEOUT=16). Each step drives one cycle of inputs on the falling edge
// and queues the hand-computed outputs expected after the next rising edge;
// a separate monitor pops and compares one entry per rising edge.
// ---------------------------------------------------------------------------
module tb_pci_bus_arbiter;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  pci_bus_arbiter_if #(.N_MASTERS(4)) bus ();

  pci_bus_arbiter #(
    .N_MASTERS   (4),
    .PARK_EN     (1'b1),
    .PARK_MASTER (0),
    .IDLE_TIMEOUT(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] gnt_n;
    logic [1:0] owner;
    logic       owner_valid;
    logic       bus_busy;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: one comparison per rising edge while expectations are queued.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = exp_q.pop_front();
      ok = (bus.gnt_n === e.gnt_n) && (bus.owner_valid === e.owner_valid) &&
           (bus.bus_busy === e.bus_busy) && (bus.timeout === e.timeout) &&
           (!e.owner_valid || (bus.owner === e.owner)) &&
           ($countones(~bus.gnt_n) <= 1);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL %s: got gnt_n=%b owner=%0d ov=%b busy=%b tmo=%b, want gnt_n=%b owner=%0d ov=%b busy=%b tmo=%b",
                 e.name, bus.gnt_n, bus.owner, bus.owner_valid, bus.bus_busy, bus.timeout,
                 e.gnt_n, e.owner, e.owner_valid, e.bus_busy, e.timeout);
      end else begin
        $display("ok   %s: gnt_n=%b owner=%0d ov=%b busy=%b tmo=%b",
                 e.name, bus.gnt_n, bus.owner, bus.owner_valid, bus.bus_busy, bus.timeout);
      end
    end
  end

  task automatic step(input string name, input bit rst, input logic [3:0] req,
                      input bit fr, input bit ir, input logic [3:0] g,
                      input int own, input bit ov, input bit busy, input bit tmo);
    exp_t e;
    @(negedge clock);
    reset       = rst;
    bus.req_n   = req;
    bus.framein = fr;
    bus.irdy    = ir;
    e.name        = name;
    e.gnt_n       = g;
    e.owner       = own[1:0];
    e.owner_valid = ov;
    e.bus_busy    = busy;
    e.timeout     = tmo;
    exp_q.push_back(e);
  endtask

  initial begin
    reset       = 1'b1;
    bus.req_n   = 4'b1111;
    bus.framein = 1'b1;
    bus.irdy    = 1'b1;

    // Reset and park
    step("rst0",        1, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0);
    step("rst1",        1, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0);
    step("park_enter",  0, 4'b1111, 1, 1, 4'b1110, 0, 1, 0, 0);
    step("park_hold",   0, 4'b1111, 1, 1, 4'b1110, 0, 1, 0, 0);

    // Round robin: masters 0 and 2 request right after reset
    step("rr_rst",      1, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0);
    step("rr_grant0",   0, 4'b1010, 1, 1, 4'b1110, 0, 1, 0, 0);
    step("rr_frame",    0, 4'b1010, 0, 1, 4'b1111, 0, 1, 1, 0);
    step("rr_data1",    0, 4'b1010, 0, 0, 4'b1111, 0, 1, 1, 0);
    step("rr_data2",    0, 4'b1010, 0, 0, 4'b1111, 0, 1, 1, 0);
    step("rr_last",     0, 4'b1011, 1, 0, 4'b1111, 0, 1, 1, 0);
    step("rr_idle",     0, 4'b1011, 1, 1, 4'b1111, 0, 0, 0, 0);
    step("rr_grant2",   0, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 0);

    // Preemption of master 2 by master 0
    step("pre_frame",   0, 4'b1011, 0, 1, 4'b1011, 2, 1, 1, 0);
    step("pre_data",    0, 4'b1011, 0, 0, 4'b1011, 2, 1, 1, 0);
    step("pre_req0",    0, 4'b1010, 0, 0, 4'b1111, 2, 1, 1, 0);
    step("pre_last",    0, 4'b1010, 1, 0, 4'b1111, 2, 1, 1, 0);
    step("pre_idle",    0, 4'b1010, 1, 1, 4'b1111, 0, 0, 0, 0);
    step("pre_grant0",  0, 4'b1010, 1, 1, 4'b1110, 0, 1, 0, 0);

    // Withdrawal in GRANT: no timeout, pointer untouched
    step("wd_drop",     0, 4'b1011, 1, 1, 4'b1111, 0, 0, 0, 0);
    step("wd_grant2",   0, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 0);
    step("wd_drop2",    0, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0);
    step("wd_park",     0, 4'b1111, 1, 1, 4'b1110, 0, 1, 0, 0);

    // Idle timeout: masters 1 and 2, master 1 never drives FRAME#
    step("to_leave",    0, 4'b1001, 1, 1, 4'b1111, 0, 0, 0, 0);
    step("to_grant1",   0, 4'b1001, 1, 1, 4'b1101, 1, 1, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      step("to_wait",   0, 4'b1001, 1, 1, 4'b1101, 1, 1, 0, 0);
    end
    step("to_expire",   0, 4'b1001, 1, 1, 4'b1111, 0, 0, 0, 1);
    step("to_grant2",   0, 4'b1001, 1, 1, 4'b1011, 2, 1, 0, 0);
    step("to_drop",     0, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0);
    step("to_park",     0, 4'b1111, 1, 1, 4'b1110, 0, 1, 0, 0);

    // Park master starts a transaction without requesting
    step("pk_frame",    0, 4'b1111, 0, 1, 4'b1111, 0, 1, 1, 0);
    step("pk_data",     0, 4'b1111, 0, 0, 4'b1111, 0, 1, 1, 0);
    step("pk_idle",     0, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0);
    step("pk_repark",   0, 4'b1111, 1, 1, 4'b1110, 0, 1, 0, 0);

    // Park master requests: gap-free PARK->GRANT, then reset mid-transaction
    step("pk_grant",    0, 4'b1110, 1, 1, 4'b1110, 0, 1, 0, 0);
    step("mid_frame",   0, 4'b1110, 0, 1, 4'b1110, 0, 1, 1, 0);
    step("mid_reset",   1, 4'b1110, 0, 0, 4'b1111, 0, 0, 0, 0);
    step("post_rst",    0, 4'b1110, 0, 0, 4'b1110, 0, 1, 0, 0);
    step("post_busy",   0, 4'b1110, 0, 0, 4'b1110, 0, 1, 1, 0);
    step("post_idle",   0, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0);

    // FRAME# and withdrawal in the same GRANT cycle: BUSY wins
    step("race_grant1", 0, 4'b1101, 1, 1, 4'b1101, 1, 1, 0, 0);
    step("race_frame",  0, 4'b1111, 0, 1, 4'b1111, 1, 1, 1, 0);
    step("race_idle",   0, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0);
    step("race_park",   0, 4'b1111, 1, 1, 4'b1110, 0, 1, 0, 0);

    // Let the monitor drain the last expectation.
    repeat (3) @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
